ws2812b_rx: RTL and testbench



---
 rtl/ws2812b_rx.sv | 173 +++++++++++++++++
 tb/tb_ws2812b_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_rx.sv
`timescale 1ns/1ps
// WS2812B single-wire receiver: decodes the first GRB word after a latch and forwards later bits on dout.
// Latency: rx_valid 1 clk after the synchronised final falling edge (3 clk after din), dout = din + 3 clk; no backpressure.
module ws2812b_rx #(
    parameter int CLOCK_MHZ    = 27,
    parameter int T1_THRESH_NS = 600,
    parameter int GLITCH_NS    = 100,
    parameter int HIGH_MAX_NS  = 2000,
    parameter int RESET_US     = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] rx_data,
    output logic        rx_valid,
    output logic        latch,
    output logic        err,
    output logic        dout
);

    localparam int THR     = CLOCK_MHZ * T1_THRESH_NS / 1000;
    localparam int GL      = CLOCK_MHZ * GLITCH_NS / 1000;
    localparam int HMAX    = CLOCK_MHZ * HIGH_MAX_NS / 1000;
    localparam int RST_CYC = CLOCK_MHZ * RESET_US;
    localparam int CW      = $clog2(((RST_CYC > HMAX) ? RST_CYC : HMAX) + 2);

    localparam logic [CW-1:0] THR_C  = CW'(THR);
    localparam logic [CW-1:0] GL_C   = CW'(GL);
    localparam logic [CW-1:0] HMAX_C = CW'(HMAX);
    localparam logic [CW-1:0] OVER_C = CW'(HMAX + 1);
    localparam logic [CW-1:0] RST_C  = CW'(RST_CYC);
    localparam logic [CW-1:0] CMAX_C = {CW{1'b1}};

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_IDLE = 2'd1,
        S_BIT  = 2'd2,
        S_FWD  = 2'd3
    } state_t;

    state_t        state_q;
    logic          sync1_q;
    logic          din_s_q;
    logic          din_d1_q;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [23:0]   sreg_q;
    logic [4:0]    bcnt_q;
    logic [23:0]   rx_data_q;
    logic          rx_valid_q;
    logic          latch_q;
    logic          err_q;
    logic          dout_q;

    logic          fall;
    logic          lcnt_hit;
    logic          over_long;
    logic          bit_ok;
    logic          bit_val;
    logic [23:0]   sreg_shift;

    // din is asynchronous to clk; two flops before anything looks at it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            din_s_q  <= 1'b0;
            din_d1_q <= 1'b0;
        end else begin
            sync1_q  <= din;
            din_s_q  <= sync1_q;
            din_d1_q <= din_s_q;
        end
    end

    always_comb begin
        hcnt_d = '0;
        lcnt_d = '0;
        if (din_s_q) begin
            hcnt_d = (hcnt_q == CMAX_C) ? hcnt_q : hcnt_q + 1'b1;
        end else begin
            lcnt_d = (lcnt_q == CMAX_C) ? lcnt_q : lcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            lcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            lcnt_q <= lcnt_d;
        end
    end

    // Saturation keeps lcnt from passing RST again in the same low period, so latch fires once
    assign fall       = din_d1_q & ~din_s_q;
    assign lcnt_hit   = (lcnt_q == RST_C);
    assign over_long  = din_s_q & (hcnt_q == OVER_C);
    assign bit_ok     = (hcnt_q >= GL_C) & (hcnt_q <= HMAX_C);
    assign bit_val    = (hcnt_q >= THR_C);
    assign sreg_shift = {sreg_q[22:0], bit_val};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_SYNC;
            sreg_q     <= '0;
            bcnt_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            latch_q    <= 1'b0;
            err_q      <= 1'b0;
            dout_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            latch_q    <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                S_SYNC: begin
                    dout_q <= 1'b0;
                    if (lcnt_hit) begin
                        latch_q <= 1'b1;
                        sreg_q  <= '0;
                        bcnt_q  <= '0;
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE, S_BIT, S_FWD: begin
                    if (over_long) begin
                        err_q   <= 1'b1;
                        dout_q  <= 1'b0;
                        sreg_q  <= '0;
                        bcnt_q  <= '0;
                        state_q <= S_SYNC;
                    end else if (lcnt_hit) begin
                        latch_q <= 1'b1;
                        dout_q  <= 1'b0;
                        sreg_q  <= '0;
                        bcnt_q  <= '0;
                        state_q <= S_IDLE;
                    end else if (state_q == S_FWD) begin
                        dout_q <= din_s_q;
                    end else begin
                        dout_q <= 1'b0;
                        if (fall && bit_ok) begin
                            if (bcnt_q == 5'd23) begin
                                rx_data_q  <= sreg_shift;
                                rx_valid_q <= 1'b1;
                                sreg_q     <= '0;
                                bcnt_q     <= '0;
                                state_q    <= S_FWD;
                            end else begin
                                sreg_q  <= sreg_shift;
                                bcnt_q  <= bcnt_q + 5'd1;
                                state_q <= S_BIT;
                            end
                        end
                    end
                end
                default: begin
                    dout_q  <= 1'b0;
                    state_q <= S_SYNC;
                end
            endcase
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign latch    = latch_q;
    assign err      = err_q;
    assign dout     = dout_q;

endmodule

// File: tb/tb_ws2812b_rx.sv
`timescale 1ns/1ps
// Directed bench for ws2812b_rx: bit waveforms 0=10 high/22 low, 1=19 high/13 low at 27 MHz defaults.
module tb_ws2812b_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic [23:0] rx_data;
    logic        rx_valid;
    logic        latch;
    logic        err;
    logic        dout;

    int errors = 0;
    int checks = 0;

    int       n_valid = 0;
    int       n_latch = 0;
    int       n_err = 0;
    int       n_dout_hi = 0;
    int       n_fwd_bad = 0;
    int       n_overlap = 0;
    logic     fwd_win = 1'b0;
    logic [2:0] hist = 3'b000;

    ws2812b_rx dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .latch    (latch),
        .err      (err),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    // Pulse counters and a din-delayed-by-3 reference for dout, sampled mid-cycle
    always @(negedge clk) begin
        if (rx_valid === 1'b1) n_valid++;
        if (latch === 1'b1) n_latch++;
        if (err === 1'b1) n_err++;
        if (dout === 1'b1) n_dout_hi++;
        if ((int'(rx_valid === 1'b1) + int'(latch === 1'b1) + int'(err === 1'b1)) > 1) n_overlap++;
        if (fwd_win && (dout !== hist[2])) n_fwd_bad++;
        hist = {hist[1:0], din};
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        n_valid   = 0;
        n_latch   = 0;
        n_err     = 0;
        n_dout_hi = 0;
        n_fwd_bad = 0;
    endtask

    task automatic send_bit(input logic b);
        din = 1'b1;
        tick(b ? 19 : 10);
        din = 1'b0;
        tick(b ? 13 : 22);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_word_glitch(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) begin
            din = 1'b1;
            tick(w[i] ? 19 : 10);
            din = 1'b0;
            tick(5);
            din = 1'b1;
            tick(1);
            din = 1'b0;
            tick(w[i] ? 7 : 16);
        end
    endtask

    task automatic idle_low(input int n);
        din = 1'b0;
        tick(n);
    endtask

    task automatic test_reset();
        int nl;
        int pos;
        nl  = 0;
        pos = -1;
        rst = 1'b1;
        din = 1'b0;
        tick(3);
        checks++; if (rx_data !== 24'h0) begin errors++; $display("FAIL reset_rx_data: got %h want 000000", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (latch !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b want 0", latch); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b want 0", dout); end
        clr();
        rst = 1'b0;
        for (int i = 1; i <= 1400; i++) begin
            tick(1);
            if (latch === 1'b1) begin
                nl++;
                if (pos < 0) pos = i;
            end
        end
        checks++; if (nl !== 1) begin errors++; $display("FAIL sync_latch_count: got %0d want 1", nl); end
        checks++; if (pos !== 1351) begin errors++; $display("FAIL sync_latch_cycle: got %0d want 1351", pos); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL sync_no_valid: got %0d want 0", n_valid); end
    endtask

    task automatic test_word();
        clr();
        send_word(24'h000505);
        checks++; if (rx_data !== 24'h000505) begin errors++; $display("FAIL word_rx_data: got %h want 000505", rx_data); end
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL word_valid_count: got %0d want 1", n_valid); end
        checks++; if (n_dout_hi !== 0) begin errors++; $display("FAIL word_dout_quiet: got %0d high cycles want 0", n_dout_hi); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL word_no_err: got %0d want 0", n_err); end
        idle_low(1400);
    endtask

    task automatic test_back_to_back();
        clr();
        send_word(24'hFF0000);
        fwd_win = 1'b1;
        send_word(24'h00FF00);
        idle_low(1400);
        fwd_win = 1'b0;
        checks++; if (rx_data !== 24'hFF0000) begin errors++; $display("FAIL b2b_rx_data: got %h want ff0000", rx_data); end
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL b2b_valid_count: got %0d want 1", n_valid); end
        checks++; if (n_fwd_bad !== 0) begin errors++; $display("FAIL b2b_dout_delay3: got %0d bad cycles want 0", n_fwd_bad); end
        checks++; if (n_dout_hi !== 312) begin errors++; $display("FAIL b2b_dout_high_cycles: got %0d want 312", n_dout_hi); end
        checks++; if (n_latch !== 1) begin errors++; $display("FAIL b2b_latch_count: got %0d want 1", n_latch); end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL b2b_dout_after_latch: got %b want 0", dout); end
    endtask

    task automatic test_glitch();
        clr();
        send_word_glitch(24'hA5A5A5);
        checks++; if (rx_data !== 24'hA5A5A5) begin errors++; $display("FAIL glitch_rx_data: got %h want a5a5a5", rx_data); end
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL glitch_valid_count: got %0d want 1", n_valid); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL glitch_no_err: got %0d want 0", n_err); end
        idle_low(1400);
    endtask

    task automatic test_overlong();
        logic [23:0] w;
        w = 24'hC3C3C3;
        clr();
        for (int i = 23; i >= 14; i--) send_bit(w[i]);
        din = 1'b1;
        tick(60);
        din = 1'b0;
        tick(22);
        send_word(24'h123456);
        checks++; if (n_err !== 1) begin errors++; $display("FAIL overlong_err_count: got %0d want 1", n_err); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL overlong_no_valid: got %0d want 0", n_valid); end
        checks++; if (rx_data !== 24'hA5A5A5) begin errors++; $display("FAIL overlong_rx_hold: got %h want a5a5a5", rx_data); end
        checks++; if (n_latch !== 0) begin errors++; $display("FAIL overlong_no_latch: got %0d want 0", n_latch); end
        clr();
        idle_low(1400);
        checks++; if (n_latch !== 1) begin errors++; $display("FAIL overlong_resync_latch: got %0d want 1", n_latch); end
    endtask

    task automatic test_reset_midword();
        logic [23:0] w;
        w = 24'h5A5A5A;
        clr();
        for (int i = 23; i >= 12; i--) send_bit(w[i]);
        din = 1'b1;
        tick(5);
        rst = 1'b1;
        #2;
        checks++; if (rx_data !== 24'h0) begin errors++; $display("FAIL midrst_rx_data: got %h want 000000", rx_data); end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL midrst_dout: got %b want 0", dout); end
        din = 1'b0;
        tick(3);
        rst = 1'b0;
        clr();
        send_word(24'h00FF00);
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL midrst_no_valid: got %0d want 0", n_valid); end
        idle_low(1400);
        checks++; if (n_latch !== 1) begin errors++; $display("FAIL midrst_latch: got %0d want 1", n_latch); end
        clr();
        send_word(24'h3C5A69);
        checks++; if (rx_data !== 24'h3C5A69) begin errors++; $display("FAIL midrst_recover_data: got %h want 3c5a69", rx_data); end
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL midrst_recover_valid: got %0d want 1", n_valid); end
    endtask

    task automatic test_exclusive();
        checks++; if (n_overlap !== 0) begin errors++; $display("FAIL pulse_exclusive: got %0d overlap cycles want 0", n_overlap); end
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        test_reset();
        test_word();
        test_back_to_back();
        test_glitch();
        test_overlong();
        test_reset_midword();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
